// File: rtl/ccg_resp_pkg.sv
// Shared types and constants for the response-side MISR collector
// and the MISR step function.
package ccg_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;
    localparam int          ONES_W   = 16;

endpackage

// File: rtl/ccg_misr_step.sv
// Combinational single-step MISR update: shift left, fold POLY on carry-out,
// then XOR in the zero-extended response.
module ccg_misr_step #(
    parameter int SIG_W = 16,
    parameter int OUT_W = 15
) (
    input  logic [SIG_W-1:0] sig_i,
    input  logic [OUT_W-1:0] resp_i,
    input  logic [SIG_W-1:0] poly_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] resp_ext_s;

    // next signature from current signature and one response vector
    always_comb begin
        resp_ext_s              = '0;
        resp_ext_s[OUT_W-1:0]   = resp_i;
        sig_o = {sig_i[SIG_W-2:0], 1'b0}
              ^ (sig_i[SIG_W-1] ? poly_i : {SIG_W{1'b0}})
              ^ resp_ext_s;
    end

endmodule

// File: rtl/ccg_resp_misr.sv
// Response collector: compacts 2^IN_W circuit responses into a MISR and
// compares against a golden signature. Optional macro CCG_RESP_ONES_EN adds ones_cnt.
module ccg_resp_misr
    import ccg_resp_pkg::*;
#(
    parameter int               IN_W  = 4,
    parameter int               OUT_W = 15,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [OUT_W-1:0]  resp_data,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic [IN_W-1:0]   vec_idx,
    output logic [SIG_W-1:0]  sig,
    output logic              done,
    output logic              pass,
    output logic [ONES_W-1:0] ones_cnt
);

    state_e           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d, sig_step_s;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic             pass_q, pass_d;
    logic             ready_q, done_q;

    ccg_misr_step #(
        .SIG_W (SIG_W),
        .OUT_W (OUT_W)
    ) u_step (
        .sig_i  (sig_q),
        .resp_i (resp_data),
        .poly_i (POLY),
        .sig_o  (sig_step_s)
    );

`ifdef CCG_RESP_ONES_EN
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [ONES_W:0]   ones_sum_s;

    function automatic logic [ONES_W-1:0] popcnt(input logic [OUT_W-1:0] v);
        logic [ONES_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + ONES_W'(v[i]);
        end
        return c;
    endfunction

    // widened sum so saturation can see the carry
    always_comb begin
        ones_sum_s = {1'b0, ones_q} + {1'b0, popcnt(resp_data)};
    end

    assign ones_cnt = ones_q;
`else
    assign ones_cnt = '0;
`endif

    // next-state and datapath updates
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
`ifdef CCG_RESP_ONES_EN
        ones_d  = ones_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    sig_d   = SEED;
                    idx_d   = '0;
                    pass_d  = 1'b0;
`ifdef CCG_RESP_ONES_EN
                    ones_d  = '0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_COLLECT: begin
                if (resp_valid) begin
                    sig_d = sig_step_s;
                    idx_d = idx_q + IN_W'(1);
`ifdef CCG_RESP_ONES_EN
                    ones_d = ones_sum_s[ONES_W] ? {ONES_W{1'b1}} : ones_sum_s[ONES_W-1:0];
`endif
                    if (idx_q == {IN_W{1'b1}}) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_CHECK: begin
                pass_d  = (sig_q == exp_sig);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers; done lags entry to DONE by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef CCG_RESP_ONES_EN
            ones_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            ready_q <= (state_d == ST_COLLECT);
            done_q  <= (state_q == ST_DONE) && (state_d == ST_DONE);
`ifdef CCG_RESP_ONES_EN
            ones_q  <= ones_d;
`endif
        end
    end

    assign resp_ready = ready_q;
    assign vec_idx    = idx_q;
    assign sig        = sig_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_ccg_resp_misr.sv
// Self-checking bench for ccg_resp_misr: directed and randomized runs scored
// against a signature/popcount reference model.
module tb_ccg_resp_misr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        resp_valid;
    logic        resp_ready;
    logic [14:0] resp_data;
    logic [15:0] exp_sig;
    logic [3:0]  vec_idx;
    logic [15:0] sig;
    logic        done;
    logic        pass;
    logic [15:0] ones_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ccg_resp_misr dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .exp_sig    (exp_sig),
        .vec_idx    (vec_idx),
        .sig        (sig),
        .done       (done),
        .pass       (pass),
        .ones_cnt   (ones_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference: signature treated as a 16-bit polynomial over GF(2), multiplied
    // by x modulo x^16+0x1021 per response, with the response added in.
    function automatic logic [15:0] model_sig(input logic [14:0] p [16]);
        int unsigned s;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            s = s * 2;
            if (s >= 65536) s = (s - 65536) ^ 32'h1021;
            s = s ^ 32'(p[i]);
        end
        return s[15:0];
    endfunction

    function automatic logic [15:0] model_ones(input logic [14:0] p [16]);
        int unsigned t;
        t = 0;
        for (int i = 0; i < 16; i++) t += $countones(p[i]);
`ifdef CCG_RESP_ONES_EN
        return (t > 65535) ? 16'hFFFF : t[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic run(input logic [14:0] p [16], input bit gaps, input logic [15:0] es,
                       input string nm);
        logic [15:0] m;
        bit          was_done;
        m        = model_sig(p);
        was_done = done;
        start    = 1'b1;
        exp_sig  = es;
        tick();
        start = 1'b0;
        check({nm, "_rdy_rise"}, 32'(resp_ready), 32'd1);
        check({nm, "_init_sig"}, 32'(sig), 32'h0000);
        check({nm, "_init_idx"}, 32'(vec_idx), 32'd0);
        check({nm, "_init_pass"}, 32'(pass), 32'd0);
        if (was_done) check({nm, "_done_drop"}, 32'(done), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    resp_valid = 1'b0;
                    resp_data  = 15'($urandom);
                    start      = 1'($urandom_range(0, 1));
                    tick();
                    check({nm, "_gap_idx"}, 32'(vec_idx), 32'(i));
                    check({nm, "_gap_rdy"}, 32'(resp_ready), 32'd1);
                end
                start = 1'b0;
            end
            resp_valid = 1'b1;
            resp_data  = p[i];
            tick();
            check({nm, "_idx"}, 32'(vec_idx), 32'((i + 1) % 16));
        end
        resp_valid = 1'b0;
        check({nm, "_chk_rdy"}, 32'(resp_ready), 32'd0);
        check({nm, "_chk_done"}, 32'(done), 32'd0);
        tick();
        check({nm, "_lat1_done"}, 32'(done), 32'd0);
        tick();
        check({nm, "_lat2_done"}, 32'(done), 32'd1);
        check({nm, "_sig"}, 32'(sig), 32'(m));
        check({nm, "_pass"}, 32'(pass), 32'(m == es));
        check({nm, "_ones"}, 32'(ones_cnt), 32'(model_ones(p)));
        // responses offered while DONE must not be consumed
        resp_valid = 1'b1;
        resp_data  = 15'($urandom);
        tick();
        tick();
        resp_valid = 1'b0;
        check({nm, "_hold_sig"}, 32'(sig), 32'(m));
        check({nm, "_hold_idx"}, 32'(vec_idx), 32'd0);
        check({nm, "_hold_done"}, 32'(done), 32'd1);
    endtask

    logic [14:0] pat [16];
    logic [14:0] rnd [16];

    initial begin
        rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp_data = '0; exp_sig = '0;
        tick(); tick();
        check("rst_rdy", 32'(resp_ready), 32'd0);
        check("rst_idx", 32'(vec_idx), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_ones", 32'(ones_cnt), 32'd0);
        rst = 1'b0;
        tick();

        foreach (pat[i]) pat[i] = 15'h0000;
        run(pat, 1'b0, 16'h0000, "zero");
        check("zero_sig_const", 32'(sig), 32'h0000);
        check("zero_pass_const", 32'(pass), 32'd1);

        pat[15] = 15'h0001;
        run(pat, 1'b0, 16'h0001, "last1");
        check("last1_pass_const", 32'(pass), 32'd1);
        run(pat, 1'b0, 16'h0002, "last1_bad");
        check("last1_bad_pass_const", 32'(pass), 32'd0);

        pat[15] = 15'h0000;
        pat[14] = 15'h0001;
        run(pat, 1'b0, 16'h0002, "shift");
        check("shift_sig_const", 32'(sig), 32'h0002);

        for (int k = 0; k < 3; k++) begin
            foreach (rnd[i]) rnd[i] = 15'($urandom);
            run(rnd, 1'b1, model_sig(rnd), "rnd_gap");
            run(rnd, 1'b0, model_sig(rnd) ^ 16'h0001, "rnd_nogap");
        end

        foreach (pat[i]) pat[i] = 15'h7FFF;
        run(pat, 1'b1, 16'h0000, "ones");
`ifdef CCG_RESP_ONES_EN
        check("ones_const", 32'(ones_cnt), 32'd240);
`else
        check("ones_const", 32'(ones_cnt), 32'd0);
`endif

        // abort mid-run at vec_idx = 7
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            resp_valid = 1'b1;
            resp_data  = 15'h7FFF;
            tick();
        end
        resp_valid = 1'b0;
        check("abort_idx7", 32'(vec_idx), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rdy", 32'(resp_ready), 32'd0);
        check("abort_idx", 32'(vec_idx), 32'd0);
        check("abort_sig", 32'(sig), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_ones", 32'(ones_cnt), 32'd0);
        tick();
        check("abort_idle_rdy", 32'(resp_ready), 32'd0);
        foreach (pat[i]) pat[i] = 15'h0000;
        run(pat, 1'b0, 16'h0000, "post_abort");
        check("post_abort_pass", 32'(pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
